countdown_120s: RTL and testbench
=================================

COUNTDOWN_120S -- requirements
Module: countdown_120s

Interface
REQ-001 Parameter START_SECS, default 120, meaning countdown load value in seconds; legal range 1..199.
REQ-002 Parameter LOW_SECS, default 10, meaning LowTime threshold in seconds.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 OneSecTimeOut  input  1  one-clk-wide pulse per elapsed second from the upstream tenths-to-seconds counter.
REQ-006 Start  input  1  level, sampled each clk; loads START_SECS and begins counting.
REQ-007 Pause  input  1  level; freezes the count while high.
REQ-008 Abort  input  1  level; returns the block to idle.
REQ-009 Hundreds  output  4  BCD hundreds digit of seconds remaining.
REQ-010 Tens  output  4  BCD tens digit of seconds remaining.
REQ-011 Ones  output  4  BCD ones digit of seconds remaining.
REQ-012 Running  output  1  high in RUN state only.
REQ-013 TimeUp  output  1  one-clk pulse when the count reaches zero.
REQ-014 LowTime  output  1  high while in RUN or PAUSE and remaining seconds are at or below LOW_SECS.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-016 The transition from IDLE to RUN SHALL occur on Start=1; the digits SHALL show START_SECS in BCD on the next clk.
REQ-017 In RUN, each OneSecTimeOut pulse SHALL decrement the BCD count by one, visible on the clk after the pulse.
REQ-018 BCD borrow: Ones 0 SHALL wrap to 9 with Tens decremented, and Tens 0 with a borrow SHALL wrap to 9 with Hundreds decremented (for example, 100 -> 099 and 010 -> 009).
REQ-019 Digits SHALL never hold a non-BCD value (A..F).
REQ-020 A tick while the count is 001 SHALL yield 000, state DONE and TimeUp=1, all on the same next clk.
REQ-021 TimeUp SHALL be high for exactly one clk per expiry.
REQ-022 RUN SHALL go to PAUSE when Pause=1, and PAUSE SHALL return to RUN when Pause=0.
REQ-023 Ticks arriving in PAUSE SHALL be ignored, not accumulated.
REQ-024 DONE SHALL hold 000 until Start=1 (reload, go to RUN) or Abort=1 (go to IDLE).
REQ-025 Abort=1 in any state SHALL go to IDLE with digits 000 on the next clk.
REQ-026 Priority SHALL be Abort > Start > Pause > tick.
REQ-027 If Start=1 and a tick occur in the same cycle, the block SHALL reload START_SECS and SHALL NOT decrement that cycle.
REQ-028 Start=1 while in RUN or PAUSE SHALL restart the count from START_SECS in RUN.
REQ-029 In IDLE, ticks SHALL be ignored and the digits SHALL stay at 000.
REQ-030 LowTime SHALL be a registered compare, updating on the same clk as the digits.
REQ-031 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-032 While rst=0, the block SHALL be asynchronously in IDLE with Hundreds=Tens=Ones=0 and Running=0, TimeUp=0, LowTime=0.
REQ-033 Assertion of rst mid-count SHALL discard the count.
REQ-034 The first Start after rst releases SHALL load START_SECS fresh.
REQ-035 No output SHALL pulse on rst release.

Structure
REQ-036 A shared package SHALL hold the state encoding constants (2 bits), the default START_SECS and LOW_SECS, and the BCD digit width constant.
REQ-037 One sub-module, bcd_digit_down, SHALL implement a single BCD digit with load, a borrow-in, and a borrow-out flagged on 0 -> 9.
REQ-038 countdown_120s SHALL instantiate bcd_digit_down three times in a borrow chain.
REQ-039 Conversion of START_SECS to BCD SHALL be elaborated from the parameter as constants, not computed at runtime.

Verification
REQ-040 Reset, Start pulse, then 120 ticks spaced 10 clk -> digits step 120, 119 ... 001, 000; TimeUp high exactly 1 clk coincident with 000; Running low after.
REQ-041 Load, tick from 100 and from 010 -> 099 and 009 respectively; no A..F ever observed (bench checks every clk).
REQ-042 Count at 057, Pause high for 5 ticks, then low, then 1 tick -> holds 057 during pause, then 056.
REQ-043 Start and tick asserted in the same clk at count 033 -> next clk shows 120, not 119.
REQ-044 Count at 011, one tick -> 010 with LowTime=1; Abort -> next clk 000, IDLE, LowTime=0, no TimeUp.
REQ-045 rst asserted asynchronously mid-count at 064 between edges -> outputs clear immediately; subsequent ticks ignored until Start.

Source files
------------

// File: rtl/countdown_120s_pkg.sv
// Shared definitions for the 120 s countdown: state encoding, defaults and
// the elaboration-time binary-to-BCD digit helper.
package countdown_120s_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int DEF_START_SECS = 120;
   localparam int DEF_LOW_SECS   = 10;
   localparam int BCD_W          = 4;

   // Extract one decimal digit (scale = 1, 10 or 100) of a constant value.
   function automatic logic [BCD_W-1:0] bcd_digit_of(input int value, input int scale);
      return BCD_W'((value / scale) % 10);
   endfunction

endpackage

// File: rtl/countdown_120s_bcd_digit_down.sv
// Single BCD down-counting digit with clear, load and borrow chaining.
// The borrow-out flags a 0 -> 9 wrap so the next digit can decrement.
module bcd_digit_down
   import countdown_120s_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [BCD_W-1:0] load_val,
   input  logic             borrow_in,
   output logic [BCD_W-1:0] digit,
   output logic [BCD_W-1:0] digit_nxt,
   output logic             borrow_out
);

   logic [BCD_W-1:0] digit_r;
   logic [BCD_W-1:0] digit_nxt_s;

   // Next digit value: clear beats load beats decrement.
   always_comb begin
      digit_nxt_s = digit_r;
      if (clr) begin
         digit_nxt_s = 4'd0;
      end else if (load) begin
         digit_nxt_s = load_val;
      end else if (digit_r > 4'd9) begin
         digit_nxt_s = 4'd0;
      end else if (borrow_in) begin
         digit_nxt_s = (digit_r == 4'd0) ? 4'd9 : (digit_r - 4'd1);
      end else begin
         digit_nxt_s = digit_r;
      end
   end

   // Digit register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digit_r <= 4'd0;
      end else begin
         digit_r <= digit_nxt_s;
      end
   end

   assign digit      = digit_r;
   assign digit_nxt  = digit_nxt_s;
   assign borrow_out = borrow_in && (digit_r == 4'd0) && !clr && !load;

endmodule

// File: rtl/countdown_120s.sv
// Seconds countdown with BCD digits, pause/abort control and a low-time flag.
// All outputs come straight from flops; the digit chain is three bcd_digit_down.
module countdown_120s
   import countdown_120s_pkg::*;
#(
   parameter int START_SECS = DEF_START_SECS,
   parameter int LOW_SECS   = DEF_LOW_SECS
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             OneSecTimeOut,
   input  logic             Start,
   input  logic             Pause,
   input  logic             Abort,
   output logic [BCD_W-1:0] Hundreds,
   output logic [BCD_W-1:0] Tens,
   output logic [BCD_W-1:0] Ones,
   output logic             Running,
   output logic             TimeUp,
   output logic             LowTime
);

   localparam logic [BCD_W-1:0] START_H = bcd_digit_of(START_SECS, 100);
   localparam logic [BCD_W-1:0] START_T = bcd_digit_of(START_SECS, 10);
   localparam logic [BCD_W-1:0] START_O = bcd_digit_of(START_SECS, 1);
   localparam logic [7:0]       LOW_LIM = 8'(LOW_SECS);

   state_t           state_r, state_nxt_s;
   logic             clr_s, load_s, dec_s, timeup_s, low_nxt_s, at_one_s;
   logic             ones_borrow_s, tens_borrow_s, hund_borrow_s;
   logic [BCD_W-1:0] hund_s, tens_s, ones_s;
   logic [BCD_W-1:0] hund_nxt_s, tens_nxt_s, ones_nxt_s;
   logic [7:0]       cnt_nxt_s;
   logic             running_r, timeup_r, lowtime_r;

   assign at_one_s = (hund_s == 4'd0) && (tens_s == 4'd0) && (ones_s == 4'd1);

   // Next-state and datapath control; Abort > Start > Pause > tick.
   always_comb begin
      state_nxt_s = state_r;
      clr_s       = 1'b0;
      load_s      = 1'b0;
      dec_s       = 1'b0;
      timeup_s    = 1'b0;
      if (Abort) begin
         state_nxt_s = ST_IDLE;
         clr_s       = 1'b1;
      end else if (Start) begin
         state_nxt_s = ST_RUN;
         load_s      = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE:  state_nxt_s = ST_IDLE;
            ST_RUN: begin
               if (Pause) begin
                  state_nxt_s = ST_PAUSE;
               end else if (OneSecTimeOut) begin
                  dec_s = 1'b1;
                  if (at_one_s) begin
                     state_nxt_s = ST_DONE;
                     timeup_s    = 1'b1;
                  end else begin
                     state_nxt_s = ST_RUN;
                  end
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_PAUSE: state_nxt_s = Pause ? ST_PAUSE : ST_RUN;
            ST_DONE:  state_nxt_s = ST_DONE;
            default: begin
               state_nxt_s = ST_IDLE;
               clr_s       = 1'b1;
            end
         endcase
      end
   end

   bcd_digit_down u_ones (
      .clk(clk), .rst(rst), .clr(clr_s), .load(load_s), .load_val(START_O),
      .borrow_in(dec_s), .digit(ones_s), .digit_nxt(ones_nxt_s), .borrow_out(ones_borrow_s)
   );

   bcd_digit_down u_tens (
      .clk(clk), .rst(rst), .clr(clr_s), .load(load_s), .load_val(START_T),
      .borrow_in(ones_borrow_s), .digit(tens_s), .digit_nxt(tens_nxt_s), .borrow_out(tens_borrow_s)
   );

   bcd_digit_down u_hund (
      .clk(clk), .rst(rst), .clr(clr_s), .load(load_s), .load_val(START_H),
      .borrow_in(tens_borrow_s), .digit(hund_s), .digit_nxt(hund_nxt_s), .borrow_out(hund_borrow_s)
   );

   // An underflowing chain is never treated as low time.
   assign cnt_nxt_s = 8'(hund_nxt_s) * 8'd100 + 8'(tens_nxt_s) * 8'd10 + 8'(ones_nxt_s);
   assign low_nxt_s = ((state_nxt_s == ST_RUN) || (state_nxt_s == ST_PAUSE))
                      && (cnt_nxt_s <= LOW_LIM) && !hund_borrow_s;

   // State and status output registers, aligned with the digit update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         running_r <= 1'b0;
         timeup_r  <= 1'b0;
         lowtime_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         running_r <= (state_nxt_s == ST_RUN);
         timeup_r  <= timeup_s;
         lowtime_r <= low_nxt_s;
      end
   end

   assign Hundreds = hund_s;
   assign Tens     = tens_s;
   assign Ones     = ones_s;
   assign Running  = running_r;
   assign TimeUp   = timeup_r;
   assign LowTime  = lowtime_r;

endmodule

// File: tb/tb_countdown_120s.sv
// Directed bench for countdown_120s: a vector table for control priority plus
// hand-written sequences for full expiry, pause, restart, abort and reset.
module tb_countdown_120s;

   logic       clk = 1'b0;
   logic       rst;
   logic       OneSecTimeOut, Start, Pause, Abort;
   logic [3:0] Hundreds, Tens, Ones;
   logic       Running, TimeUp, LowTime;

   int total = 0;
   int bad   = 0;
   int tu_cnt = 0;

   typedef struct {
      logic start, pause, abort, tick;
      int   h, t, o, run, tu, low;
   } vec_t;

   vec_t vecs[15];

   always #5 clk = ~clk;

   countdown_120s #(.START_SECS(120), .LOW_SECS(10)) dut (
      .clk(clk), .rst(rst), .OneSecTimeOut(OneSecTimeOut), .Start(Start),
      .Pause(Pause), .Abort(Abort), .Hundreds(Hundreds), .Tens(Tens), .Ones(Ones),
      .Running(Running), .TimeUp(TimeUp), .LowTime(LowTime)
   );

   task automatic chk(input string name, input integer got, input integer exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic chk_out(input string name, input int h, input int t, input int o,
                          input int r, input int tu, input int l);
      chk({name, ".hundreds"}, Hundreds, h);
      chk({name, ".tens"},     Tens,     t);
      chk({name, ".ones"},     Ones,     o);
      chk({name, ".running"},  Running,  r);
      chk({name, ".timeup"},   TimeUp,   tu);
      chk({name, ".lowtime"},  LowTime,  l);
   endtask

   task automatic chk_val(input string name, input int v, input int r, input int tu, input int l);
      chk_out(name, v / 100, (v / 10) % 10, v % 10, r, tu, l);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         OneSecTimeOut = 1'b1;
         cyc();
         OneSecTimeOut = 1'b0;
      end
   endtask

   task automatic do_start();
      Start = 1'b1;
      cyc();
      Start = 1'b0;
   endtask

   // Every clock: digits must be BCD; count TimeUp pulses.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         total++;
         if (Hundreds > 4'd9 || Tens > 4'd9 || Ones > 4'd9 ||
             $isunknown({Hundreds, Tens, Ones})) begin
            bad++;
            $display("FAIL bcd_digit got=%0h%0h%0h exp=digits 0..9", Hundreds, Tens, Ones);
         end
         if (TimeUp === 1'b1) tu_cnt++;
      end
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 2, 0, 1, 0, 0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 9, 1, 0, 0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 9, 1, 0, 0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 8, 1, 0, 0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 8, 0, 0, 0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 8, 0, 0, 0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 8, 1, 0, 0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 7, 1, 0, 0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 2, 0, 1, 0, 0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 2, 0, 1, 0, 0};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 2, 0, 1, 0, 0};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0};

      rst = 1'b0;
      OneSecTimeOut = 1'b0; Start = 1'b0; Pause = 1'b0; Abort = 1'b0;
      #12;
      chk_out("reset_hold", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      cyc();
      chk_out("reset_release", 0, 0, 0, 0, 0, 0);

      // Control priority table.
      for (int i = 0; i < 15; i++) begin
         Start = vecs[i].start; Pause = vecs[i].pause;
         Abort = vecs[i].abort; OneSecTimeOut = vecs[i].tick;
         cyc();
         chk_out($sformatf("vec%0d", i), vecs[i].h, vecs[i].t, vecs[i].o,
                 vecs[i].run, vecs[i].tu, vecs[i].low);
      end
      Start = 1'b0; Pause = 1'b0; Abort = 1'b0; OneSecTimeOut = 1'b0;
      cyc();
      chk("tu_cnt_table", tu_cnt, 0);

      // Full expiry: 120 ticks spaced 10 clocks.
      do_start();
      chk_val("full_load", 120, 1, 0, 0);
      for (int e = 119; e >= 0; e--) begin
         tick_n(1);
         chk_val($sformatf("full_%0d", e), e, (e != 0) ? 1 : 0, (e == 0) ? 1 : 0,
                 (e != 0 && e <= 10) ? 1 : 0);
         repeat (9) cyc();
      end
      chk_val("done_hold", 0, 0, 0, 0);
      chk("tu_cnt_full", tu_cnt, 1);
      tick_n(2);
      chk_val("done_tick_ignored", 0, 0, 0, 0);

      // Pause at 057 for 5 ticks, resume, one tick.
      do_start();
      tick_n(63);
      chk_val("pause_pre", 57, 1, 0, 0);
      Pause = 1'b1;
      cyc();
      chk_val("pause_enter", 57, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick_n(1);
         chk_val($sformatf("pause_tick%0d", i), 57, 0, 0, 0);
      end
      Pause = 1'b0;
      cyc();
      chk_val("pause_exit", 57, 1, 0, 0);
      tick_n(1);
      chk_val("pause_resume_tick", 56, 1, 0, 0);

      // Start and tick together at 033.
      do_start();
      tick_n(87);
      chk_val("restart_pre", 33, 1, 0, 0);
      Start = 1'b1; OneSecTimeOut = 1'b1;
      cyc();
      Start = 1'b0; OneSecTimeOut = 1'b0;
      chk_val("restart_tick", 120, 1, 0, 0);

      // LowTime entry at 010, then abort.
      tu_cnt = 0;
      tick_n(109);
      chk_val("low_pre", 11, 1, 0, 0);
      tick_n(1);
      chk_val("low_enter", 10, 1, 0, 1);
      Abort = 1'b1;
      cyc();
      Abort = 1'b0;
      chk_val("abort_low", 0, 0, 0, 0);
      chk("tu_cnt_abort", tu_cnt, 0);

      // Asynchronous reset mid-count at 064.
      do_start();
      tick_n(56);
      chk_val("rst_pre", 64, 1, 0, 0);
      #3;
      rst = 1'b0;
      #1;
      chk_val("rst_async", 0, 0, 0, 0);
      OneSecTimeOut = 1'b1;
      cyc();
      OneSecTimeOut = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      cyc();
      chk_val("rst_release", 0, 0, 0, 0);
      tick_n(3);
      chk_val("rst_ticks_ignored", 0, 0, 0, 0);
      do_start();
      chk_val("rst_fresh_start", 120, 1, 0, 0);
      tick_n(1);
      chk_val("rst_fresh_tick", 119, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
